// File: rtl/aurora_rx_pkg.sv
// rtl/aurora_rx_pkg.sv - shared types and helpers for the Aurora RX packer
package aurora_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DROP = 2'd2
    } state_t;

    function automatic int nwords_width(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Clear has priority, so an increment coinciding with clear is lost.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aurora_rx_packer.sv
// rtl/aurora_rx_packer.sv - packs LocalLink RX beats into wide framed FIFO words
module aurora_rx_packer
    import aurora_rx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RATIO = 4,
    parameter int CNT_W = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              link_active,
    input  logic [WIDTH-1:0]                  rx_d,
    input  logic                              rx_src_rdy_n,
    input  logic                              rx_sof_n,
    input  logic                              rx_eof_n,
    input  logic                              clr_stats,
    output logic [WIDTH*RATIO-1:0]            fifo_data_o,
    output logic [nwords_width(RATIO)-1:0]    fifo_nwords_o,
    output logic                              fifo_first_o,
    output logic                              fifo_last_o,
    output logic                              fifo_wren_o,
    input  logic                              fifo_full_i,
    output logic [CNT_W-1:0]                  drop_cnt_o,
    output logic [CNT_W-1:0]                  ferr_cnt_o,
    output logic                              overflow_o
);

    localparam int NW = nwords_width(RATIO);
    localparam int DW = WIDTH * RATIO;

    state_t          state, state_n;
    logic [NW-1:0]   idx, idx_n;
    logic [DW-1:0]   acc, acc_n;
    logic            first_pend, first_pend_n;

    logic            beat, sof, eof;
    logic            cmp, flush, wr, drop_inc, ferr_inc;
    logic [DW-1:0]   cmp_data, lane_word, lane0_word;
    logic [NW-1:0]   cmp_nw;
    logic            cmp_first, cmp_last;

    assign beat = link_active && !rx_src_rdy_n;
    assign sof  = !rx_sof_n;
    assign eof  = !rx_eof_n;

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        acc_n        = acc;
        first_pend_n = first_pend;
        cmp          = 1'b0;
        flush        = 1'b0;
        cmp_data     = '0;
        cmp_nw       = '0;
        cmp_first    = 1'b0;
        cmp_last     = 1'b0;
        ferr_inc     = 1'b0;

        lane0_word            = '0;
        lane0_word[WIDTH-1:0] = rx_d;
        lane_word             = (idx == '0) ? '0 : acc;
        lane_word[int'(idx)*WIDTH +: WIDTH] = rx_d;

        if (beat) begin
            if (state == PACK && sof) begin
                ferr_inc = 1'b1;
                if (idx != '0) begin
                    cmp       = 1'b1;
                    flush     = 1'b1;
                    cmp_data  = acc;
                    cmp_nw    = idx;
                    cmp_first = first_pend;
                    cmp_last  = 1'b1;
                end
            end

            if (sof && flush && eof) begin
                // Only one word can be written per cycle: the flush wins and the
                // colliding single-beat frame is discarded.
                state_n      = IDLE;
                idx_n        = '0;
                acc_n        = '0;
                first_pend_n = 1'b0;
            end else if (sof) begin
                if (eof || RATIO == 1) begin
                    cmp          = 1'b1;
                    cmp_data     = lane0_word;
                    cmp_nw       = NW'(1);
                    cmp_first    = 1'b1;
                    cmp_last     = eof;
                    state_n      = eof ? IDLE : PACK;
                    idx_n        = '0;
                    acc_n        = '0;
                    first_pend_n = 1'b0;
                end else begin
                    state_n      = PACK;
                    idx_n        = NW'(1);
                    acc_n        = lane0_word;
                    first_pend_n = 1'b1;
                end
            end else begin
                case (state)
                    IDLE: ferr_inc = 1'b1;
                    DROP: if (eof) state_n = IDLE;
                    PACK: begin
                        if (idx == NW'(RATIO - 1) || eof) begin
                            cmp          = 1'b1;
                            cmp_data     = lane_word;
                            cmp_nw       = idx + 1'b1;
                            cmp_first    = first_pend;
                            cmp_last     = eof;
                            state_n      = eof ? IDLE : PACK;
                            idx_n        = '0;
                            acc_n        = '0;
                            first_pend_n = 1'b0;
                        end else begin
                            idx_n = idx + 1'b1;
                            acc_n = lane_word;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        wr       = cmp && !fifo_full_i;
        drop_inc = cmp && fifo_full_i;
        // A flushed word closes the old frame; the new one keeps packing.
        if (drop_inc && !flush) begin
            state_n = cmp_last ? IDLE : DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !link_active) begin
            state         <= IDLE;
            idx           <= '0;
            acc           <= '0;
            first_pend    <= 1'b0;
            fifo_data_o   <= '0;
            fifo_nwords_o <= '0;
            fifo_first_o  <= 1'b0;
            fifo_last_o   <= 1'b0;
            fifo_wren_o   <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            acc         <= acc_n;
            first_pend  <= first_pend_n;
            fifo_wren_o <= wr;
            if (wr) begin
                fifo_data_o   <= cmp_data;
                fifo_nwords_o <= cmp_nw;
                fifo_first_o  <= cmp_first;
                fifo_last_o   <= cmp_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            overflow_o <= 1'b0;
        end else if (drop_inc) begin
            overflow_o <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_inc),
        .clr (clr_stats),
        .cnt (drop_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ferr_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ferr_inc),
        .clr (clr_stats),
        .cnt (ferr_cnt_o)
    );

endmodule

// File: tb/tb_aurora_rx_packer.sv
// tb/tb_aurora_rx_packer.sv - scoreboard bench for aurora_rx_packer
module tb_aurora_rx_packer;

    localparam int WIDTH = 32;
    localparam int RATIO = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [127:0] d;
        logic [2:0]   nw;
        logic         f;
        logic         l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         link_active = 1'b1;
    logic [31:0]  rx_d = '0;
    logic         rx_src_rdy_n = 1'b1;
    logic         rx_sof_n = 1'b1;
    logic         rx_eof_n = 1'b1;
    logic         clr_stats = 1'b0;
    logic [127:0] fifo_data_o;
    logic [2:0]   fifo_nwords_o;
    logic         fifo_first_o;
    logic         fifo_last_o;
    logic         fifo_wren_o;
    logic         fifo_full_i = 1'b0;
    logic [3:0]   drop_cnt_o;
    logic [3:0]   ferr_cnt_o;
    logic         overflow_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    aurora_rx_packer #(.WIDTH(WIDTH), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .link_active   (link_active),
        .rx_d          (rx_d),
        .rx_src_rdy_n  (rx_src_rdy_n),
        .rx_sof_n      (rx_sof_n),
        .rx_eof_n      (rx_eof_n),
        .clr_stats     (clr_stats),
        .fifo_data_o   (fifo_data_o),
        .fifo_nwords_o (fifo_nwords_o),
        .fifo_first_o  (fifo_first_o),
        .fifo_last_o   (fifo_last_o),
        .fifo_wren_o   (fifo_wren_o),
        .fifo_full_i   (fifo_full_i),
        .drop_cnt_o    (drop_cnt_o),
        .ferr_cnt_o    (ferr_cnt_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] w4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    always @(negedge clk) begin
        if (fifo_wren_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: data=%h nw=%0d f=%0b l=%0b, no word expected",
                         fifo_data_o, fifo_nwords_o, fifo_first_o, fifo_last_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({fifo_data_o, fifo_nwords_o, fifo_first_o, fifo_last_o} !== e) begin
                    errors++;
                    $display("FAIL word: got data=%h nw=%0d f=%0b l=%0b, want data=%h nw=%0d f=%0b l=%0b",
                             fifo_data_o, fifo_nwords_o, fifo_first_o, fifo_last_o,
                             e.d, e.nw, e.f, e.l);
                end
            end
        end
    end

    task automatic expect_word(input logic [127:0] d, input int nw, input logic f, input logic l);
        exp_t e;
        e.d  = d;
        e.nw = 3'(nw);
        e.f  = f;
        e.l  = l;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e);
        rx_d         = d;
        rx_src_rdy_n = 1'b0;
        rx_sof_n     = ~s;
        rx_eof_n     = ~e;
        @(posedge clk);
        #1;
        rx_src_rdy_n = 1'b1;
        rx_sof_n     = 1'b1;
        rx_eof_n     = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        @(negedge clk);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_stats(input string name, input int drop, input int ferr, input logic ovf);
        @(negedge clk);
        checks++;
        if ({drop_cnt_o, ferr_cnt_o, overflow_o} !== {4'(drop), 4'(ferr), ovf}) begin
            errors++;
            $display("FAIL %s: got drop=%0d ferr=%0d ovf=%0b, want drop=%0d ferr=%0d ovf=%0b",
                     name, drop_cnt_o, ferr_cnt_o, overflow_o, drop, ferr, ovf);
        end
    endtask

    task automatic check_all_zero(input string name);
        @(negedge clk);
        checks++;
        if ({fifo_data_o, fifo_nwords_o, fifo_first_o, fifo_last_o, fifo_wren_o,
             drop_cnt_o, ferr_cnt_o, overflow_o} !== '0) begin
            errors++;
            $display("FAIL %s: outputs not zero (wren=%0b data=%h nw=%0d drop=%0d ferr=%0d ovf=%0b)",
                     name, fifo_wren_o, fifo_data_o, fifo_nwords_o, drop_cnt_o, ferr_cnt_o, overflow_o);
        end
    endtask

    initial begin
        idle(3);
        check_all_zero("reset_state");
        rst = 1'b0;
        idle(1);

        // 8-beat frame: two full words
        expect_word(w4(1, 2, 3, 4), 4, 1'b1, 1'b0);
        expect_word(w4(5, 6, 7, 8), 4, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) send(32'(i), i == 1, i == 8);
        idle(2);

        // 6-beat frame: partial tail word
        expect_word(w4('h11, 'h12, 'h13, 'h14), 4, 1'b1, 1'b0);
        expect_word(w4('h15, 'h16, 0, 0), 2, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) send(32'('h10 + i), i == 1, i == 6);
        idle(2);

        // single-beat frame
        expect_word(w4('hAA, 0, 0, 0), 1, 1'b1, 1'b1);
        send(32'hAA, 1'b1, 1'b1);
        idle(2);
        check_stats("stats_clean", 0, 0, 1'b0);

        // overflow on the second word of a 12-beat frame
        expect_word(w4('h21, 'h22, 'h23, 'h24), 4, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            fifo_full_i = (i == 8);
            send(32'('h20 + i), i == 1, i == 12);
        end
        fifo_full_i = 1'b0;
        idle(2);
        check_stats("stats_after_drop", 1, 0, 1'b1);

        expect_word(w4('h31, 'h32, 'h33, 'h34), 4, 1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) send(32'('h30 + i), i == 1, i == 4);
        idle(2);

        // SOF in the middle of a frame
        expect_word(w4('h41, 'h42, 0, 0), 2, 1'b1, 1'b1);
        expect_word(w4('h51, 'h52, 'h53, 0), 3, 1'b1, 1'b1);
        send(32'h41, 1'b1, 1'b0);
        send(32'h42, 1'b0, 1'b0);
        send(32'h51, 1'b1, 1'b0);
        send(32'h52, 1'b0, 1'b0);
        send(32'h53, 1'b0, 1'b1);
        idle(2);
        check_stats("stats_after_midsof", 1, 1, 1'b1);
        send(32'h60, 1'b0, 1'b0);
        idle(2);
        check_stats("stats_after_stray_beat", 1, 2, 1'b1);

        // link loss mid-frame: partial data must not resurface
        send(32'h71, 1'b1, 1'b0);
        send(32'h72, 1'b0, 1'b0);
        send(32'h73, 1'b0, 1'b0);
        link_active = 1'b0;
        send(32'h74, 1'b0, 1'b1);
        idle(1);
        link_active = 1'b1;
        expect_word(w4('h81, 'h82, 0, 0), 2, 1'b1, 1'b1);
        send(32'h81, 1'b1, 1'b0);
        send(32'h82, 1'b0, 1'b1);
        idle(2);
        check_stats("stats_after_relink", 1, 2, 1'b1);
        clr_stats = 1'b1;
        idle(1);
        clr_stats = 1'b0;
        check_stats("stats_after_clear", 0, 0, 1'b0);

        // drive the drop counter to all-ones-1, then past saturation
        fifo_full_i = 1'b1;
        for (int i = 0; i < 14; i++) send(32'(i), 1'b1, 1'b1);
        idle(1);
        check_stats("drop_at_14", 14, 0, 1'b1);
        for (int i = 0; i < 3; i++) send(32'(i), 1'b1, 1'b1);
        idle(1);
        check_stats("drop_saturated", 15, 0, 1'b1);
        fifo_full_i = 1'b0;

        // reset mid-frame, landing on what would be a completing beat
        send(32'h91, 1'b1, 1'b0);
        send(32'h92, 1'b0, 1'b0);
        send(32'h93, 1'b0, 1'b0);
        rst = 1'b1;
        send(32'h94, 1'b0, 1'b0);
        check_all_zero("reset_mid_frame");
        rst = 1'b0;
        send(32'h95, 1'b0, 1'b1);
        idle(2);
        check_stats("stats_after_reset", 0, 1, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aurora_rx_packer.md
Name: aurora_rx_packer

Overview:
- Frame-aware receive bridge from an Aurora LocalLink RX port into a wide write-only FIFO.
- Packs RATIO consecutive WIDTH-bit beats into one FIFO word of WIDTH*RATIO bits and tags the first and last words of each frame.
- Drops whole frames on FIFO overflow and keeps saturating error statistics.
- Sits between the Aurora core RX user interface and the trigger-consolidation input FIFO.

Parameters:
- WIDTH, 32, Aurora user-data beat width in bits.
- RATIO, 4, beats packed per FIFO word (>=1; 1 gives pass-through with framing).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  user clock of the Aurora core.
- rst  in  1  synchronous, active-high reset.
- link_active  in  1  Aurora channel up.
- rx_d  in  WIDTH  receive data beat.
- rx_src_rdy_n  in  1  beat valid, active-low; no backpressure exists.
- rx_sof_n  in  1  start of frame, active-low, qualified by valid.
- rx_eof_n  in  1  end of frame, active-low, qualified by valid.
- clr_stats  in  1  synchronous clear of counters and sticky flag.
- fifo_data_o  out  WIDTH*RATIO  packed word; beat 0 in bits [WIDTH-1:0].
- fifo_nwords_o  out  $clog2(RATIO)+1  number of valid beats in the word (1..RATIO).
- fifo_first_o  out  1  word holds the frame's first beat.
- fifo_last_o  out  1  word holds the frame's last beat.
- fifo_wren_o  out  1  write strobe, one cycle per word.
- fifo_full_i  in  1  FIFO prog-full; must assert when at most 1 entry is free.
- drop_cnt_o  out  CNT_W  frames dropped for overflow, saturating.
- ferr_cnt_o  out  CNT_W  framing errors, saturating.
- overflow_o  out  1  sticky: at least one drop since reset or clr_stats.

Behaviour:
- Reset: every output is 0. State is IDLE and the beat index is 0.
- link_active=0 acts as a reset for the state, index and output registers. Counters and overflow_o hold their values. A frame in progress when the link drops is abandoned silently.
- A beat is accepted when rx_src_rdy_n=0.
- States and transitions:
  - IDLE: an accepted beat with SOF loads lane 0 and goes to PACK. An accepted beat without SOF is discarded and increments ferr_cnt_o.
  - PACK: each beat loads lane idx and idx increments.
  - A word completes when idx reaches RATIO-1 or on EOF.
  - On completion, the registered outputs update and fifo_wren_o pulses on the next cycle (latency 1). Lanes above nwords are 0.
  - EOF returns the block to IDLE with idx=0. A full word without EOF stays in PACK with idx=0.
- Single-beat frame (SOF and EOF together): one word with nwords=1, first=1, last=1.
- SOF while in PACK (missing EOF):
  - The partial word is flushed with last=1 and ferr_cnt_o increments.
  - If nothing is accumulated, only the counter increments.
  - Flushing and loading the new beat into lane 0 happen in the same cycle; the new frame continues in PACK.
- Overflow:
  - fifo_full_i is sampled on the completing cycle. If it is 1, the word is not written.
  - drop_cnt_o increments, overflow_o sets, and the block enters DROP.
  - If the word also had EOF, it returns to IDLE instead.
  - Words of that frame already written remain in the FIFO. Downstream detects truncation as first=1 without a preceding last=1.
- DROP: beats are discarded until EOF, then IDLE. SOF in DROP starts a new frame in PACK, behaving as an accepted SOF beat.
- fifo_first_o is set on the first word written for a frame only.
- Counters saturate at all-ones.
- clr_stats clears the counters and overflow_o. An increment in the same cycle is lost, because clear wins.

Decomposition:
- Shared package aurora_rx_pkg holds:
  - the state enum {IDLE, PACK, DROP};
  - a function computing nwords width from RATIO.
- Natural sub-module: sat_counter (CNT_W parameter, inc, clr), instantiated twice.

Test Plan:
- RATIO=4, 8-beat frame 0x1..0x8 with FIFO not full -> 2 writes: {4,3,2,1} first=1 nwords=4, then {8,7,6,5} last=1 nwords=4. Counters stay 0.
- 6-beat frame -> second word {0,0,6,5}, nwords=2, last=1. Single-beat frame 0xAA -> one word nwords=1, first=last=1.
- fifo_full_i=1 on the second word's completion of a 12-beat frame -> only word 1 written. Remaining beats discarded, drop_cnt_o=1, overflow_o=1. The next frame is packed normally.
- SOF mid-frame after 2 beats -> word nwords=2 last=1 written, ferr_cnt_o=1, new frame packs from lane 0. A valid beat without SOF in IDLE -> no write, ferr_cnt_o=2.
- link_active drops after 3 beats, then a frame arrives after relink -> no stale data is written. Counters are retained and clr_stats zeroes them.
- Force drop_cnt_o to all-ones-1, then 3 overflows -> saturates at all-ones. Reset mid-frame -> all outputs 0 in the next cycle.
